// File: rtl/ysyx_23060171_defs_pkg.sv
// Shared definitions for the ysyx_23060171 control path: state encodings,
// error codes and the reset instruction.
package ysyx_23060171_defs;

  localparam logic [2:0] ST_IF_REQ  = 3'd0;
  localparam logic [2:0] ST_IF_WAIT = 3'd1;
  localparam logic [2:0] ST_EX      = 3'd2;
  localparam logic [2:0] ST_LS_REQ  = 3'd3;
  localparam logic [2:0] ST_LS_WAIT = 3'd4;
  localparam logic [2:0] ST_WB      = 3'd5;
  localparam logic [2:0] ST_HALT    = 3'd6;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_EBREAK   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // States that wait on an external handshake and are guarded by the timer.
  function automatic logic is_timed_state(input logic [2:0] st);
    return (st == ST_IF_REQ) || (st == ST_IF_WAIT) ||
           (st == ST_LS_REQ) || (st == ST_LS_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_23060171_tmo.sv
// Handshake watchdog: counts cycles spent in one waiting state and flags
// expiry once the count reaches TIMEOUT.
module ysyx_23060171_tmo #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // Saturates at LIMIT so a stalled enable never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/ysyx_23060171_ctrl.sv
// Multi-cycle core controller: sequences fetch, execute, load/store and
// write-back, tracks PC and retired count, and halts on ebreak or faults.
module ysyx_23060171_ctrl
  import ysyx_23060171_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  output logic        ifu_rsp_ready,
  input  logic [31:0] ifu_rsp_data,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        is_mem,
  input  logic        is_ebreak,
  output logic        reg_wen_gate,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halt,
  output logic [1:0]  err
);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] instret_q;
  logic [1:0]  err_q;
  logic [1:0]  err_nxt;
  logic        tmo_expired;
  logic        tmo_clr;
  logic        abort;
  logic        pc_misaligned;

  assign pc_misaligned = (next_pc[1:0] != 2'b00);

  // Each waiting state checks its own handshake input before the timer, so a
  // handshake landing on the expiry cycle completes instead of aborting.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    abort     = 1'b0;
    case (state)
      ST_IF_REQ: begin
        if (ifu_req_ready)    state_nxt = ST_IF_WAIT;
        else if (tmo_expired) abort     = 1'b1;
      end
      ST_IF_WAIT: begin
        if (ifu_rsp_valid)    state_nxt = ST_EX;
        else if (tmo_expired) abort     = 1'b1;
      end
      ST_EX: begin
        if (is_ebreak) begin
          state_nxt = ST_HALT;
          err_nxt   = ERR_EBREAK;
        end else if (is_mem) begin
          state_nxt = ST_LS_REQ;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_LS_REQ: begin
        if (lsu_req_ready)    state_nxt = ST_LS_WAIT;
        else if (tmo_expired) abort     = 1'b1;
      end
      ST_LS_WAIT: begin
        if (lsu_rsp_valid)    state_nxt = ST_WB;
        else if (tmo_expired) abort     = 1'b1;
      end
      ST_WB: begin
        if (pc_misaligned) begin
          state_nxt = ST_HALT;
          err_nxt   = ERR_MISALIGN;
        end else begin
          state_nxt = ST_IF_REQ;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_HALT;
    endcase
    if (abort) begin
      state_nxt = ST_HALT;
      err_nxt   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IF_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= INST_NOP;
      instret_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if ((state == ST_IF_WAIT) && ifu_rsp_valid) begin
        inst_q <= ifu_rsp_data;
      end
      if (state == ST_WB) begin
        instret_q <= instret_q + 32'd1;
        if (!pc_misaligned) begin
          pc_q <= next_pc;
        end
      end
    end
  end

  // Any state change re-arms the watchdog, so each waiting state starts at zero.
  assign tmo_clr = (state_nxt != state);

  ysyx_23060171_tmo #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (is_timed_state(state)),
    .expired (tmo_expired)
  );

  // Handshake and strobe outputs are held low while rst is asserted.
  assign ifu_req_valid = !rst && (state == ST_IF_REQ)  && !abort;
  assign ifu_rsp_ready = !rst && (state == ST_IF_WAIT) && !abort;
  assign lsu_req_valid = !rst && (state == ST_LS_REQ)  && !abort;
  assign reg_wen_gate  = !rst && (state == ST_WB);
  assign retire        = !rst && (state == ST_WB);
  assign halt          = !rst && (state == ST_HALT);
  assign err           = rst ? ERR_NONE : err_q;

  assign ifu_addr = pc_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_ysyx_23060171_ctrl.sv
// Directed bench for ysyx_23060171_ctrl: retire records go into a scoreboard
// queue when the fetch response is set up and are checked on each retire.
module tb_ysyx_23060171_ctrl;
  import ysyx_23060171_defs::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int unsigned TMO    = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b0;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_data = 32'h0;
  logic        lsu_req_valid;
  logic        lsu_req_ready = 1'b0;
  logic        lsu_rsp_valid = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] next_pc = 32'h0;
  logic        is_mem = 1'b0;
  logic        is_ebreak = 1'b0;
  logic        reg_wen_gate;
  logic        retire;
  logic [31:0] instret;
  logic        halt;
  logic [1:0]  err;

  ysyx_23060171_ctrl #(
    .RESET_PC(RST_PC),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr     (ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_data (ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid),
    .inst         (inst),
    .pc           (pc),
    .next_pc      (next_pc),
    .is_mem       (is_mem),
    .is_ebreak    (is_ebreak),
    .reg_wen_gate (reg_wen_gate),
    .retire       (retire),
    .instret      (instret),
    .halt         (halt),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] instret;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] p, input logic [31:0] i, input logic [31:0] n);
    exp_t e;
    e.pc = p;
    e.inst = i;
    e.instret = n;
    sb.push_back(e);
  endtask

  task automatic sb_retire();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_underflow: observed retire with empty queue, expected a queued record");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ret_pc", pc, e.pc);
      check("ret_inst", inst, e.inst);
      check("ret_instret", instret, e.instret);
      checkb("ret_wen_gate", reg_wen_gate, 1'b1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = 32'h0;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    next_pc       = 32'h0;
    is_mem        = 1'b0;
    is_ebreak     = 1'b0;
    tick();
    tick();
  endtask

  int ret_cyc;
  int halt_cyc;
  int n_ret;
  int n_lsu;

  initial begin
    // Reset state
    apply_reset();
    tick();
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, INST_NOP);
    check("rst_instret", instret, 32'h0);
    checkb("rst_halt", halt, 1'b0);
    check("rst_err", 32'(err), 32'(ERR_NONE));
    checkb("rst_ifu_req_valid", ifu_req_valid, 1'b0);
    checkb("rst_ifu_rsp_ready", ifu_rsp_ready, 1'b0);
    checkb("rst_lsu_req_valid", lsu_req_valid, 1'b0);
    checkb("rst_retire", retire, 1'b0);
    checkb("rst_wen_gate", reg_wen_gate, 1'b0);

    // Zero-wait ALU instruction: fetch at cycle 1, retire at cycle 4
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0050_0093;
    next_pc       = 32'h8000_0004;
    sb_push(RST_PC, 32'h0050_0093, 32'd0);
    rst = 1'b0;
    settle();
    checkb("alu_c1_req_valid", ifu_req_valid, 1'b1);
    check("alu_c1_addr", ifu_addr, RST_PC);
    checkb("alu_c1_rsp_ready", ifu_rsp_ready, 1'b0);
    check("alu_c1_inst_ignored", inst, INST_NOP);
    tick();
    checkb("alu_c2_rsp_ready", ifu_rsp_ready, 1'b1);
    checkb("alu_c2_req_valid", ifu_req_valid, 1'b0);
    tick();
    check("alu_c3_inst", inst, 32'h0050_0093);
    checkb("alu_c3_retire", retire, 1'b0);
    tick();
    checkb("alu_c4_retire", retire, 1'b1);
    if (retire) sb_retire();
    tick();
    check("alu_c5_pc", pc, 32'h8000_0004);
    check("alu_c5_instret", instret, 32'd1);
    checkb("alu_c5_retire", retire, 1'b0);
    check("alu_c5_addr", ifu_addr, 32'h8000_0004);

    // Fetch request stalled for 3 cycles, retire at cycle 7
    apply_reset();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h00a0_0113;
    next_pc       = 32'h8000_0004;
    sb_push(RST_PC, 32'h00a0_0113, 32'd0);
    rst = 1'b0;
    settle();
    for (int c = 1; c <= 3; c++) begin
      checkb("stall_req_valid", ifu_req_valid, 1'b1);
      check("stall_addr", ifu_addr, RST_PC);
      tick();
    end
    ifu_req_ready = 1'b1;
    settle();
    ret_cyc = 0;
    for (int c = 4; c <= 8; c++) begin
      if (retire && ret_cyc == 0) begin
        ret_cyc = c;
        sb_retire();
      end
      tick();
    end
    check("stall_retire_cycle", ret_cyc, 7);

    // Load with response delayed 2 cycles: retire at cycle 8, one LSU handshake
    apply_reset();
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0000_2083;
    next_pc       = 32'h8000_0004;
    is_mem        = 1'b1;
    lsu_req_ready = 1'b1;
    sb_push(RST_PC, 32'h0000_2083, 32'd0);
    rst = 1'b0;
    ret_cyc = 0;
    n_lsu = 0;
    for (int c = 1; c <= 8; c++) begin
      lsu_rsp_valid = (c == 7);
      if (c >= 3) ifu_rsp_data = 32'hdead_beef;
      settle();
      if (lsu_req_valid && lsu_req_ready) n_lsu++;
      if (c >= 3) begin
        check("load_inst_stable", inst, 32'h0000_2083);
        check("load_pc_stable", pc, RST_PC);
      end
      if (retire && ret_cyc == 0) begin
        ret_cyc = c;
        sb_retire();
      end
      tick();
    end
    check("load_retire_cycle", ret_cyc, 8);
    check("load_lsu_handshakes", n_lsu, 1);

    // Zero-wait memory instruction takes 6 cycles
    apply_reset();
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0010_a023;
    next_pc       = 32'h8000_0004;
    is_mem        = 1'b1;
    lsu_req_ready = 1'b1;
    lsu_rsp_valid = 1'b1;
    sb_push(RST_PC, 32'h0010_a023, 32'd0);
    rst = 1'b0;
    settle();
    ret_cyc = 0;
    for (int c = 1; c <= 7; c++) begin
      if (retire && ret_cyc == 0) begin
        ret_cyc = c;
        sb_retire();
      end
      tick();
    end
    check("mem0_retire_cycle", ret_cyc, 6);

    // ebreak beats is_mem, halts with err=01, no retire
    apply_reset();
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0010_0073;
    next_pc       = 32'h8000_0004;
    is_ebreak     = 1'b1;
    is_mem        = 1'b1;
    lsu_req_ready = 1'b1;
    rst = 1'b0;
    settle();
    n_ret = 0;
    n_lsu = 0;
    halt_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      if (retire) n_ret++;
      if (lsu_req_valid) n_lsu++;
      if (halt && halt_cyc == 0) halt_cyc = c;
      tick();
    end
    check("ebreak_halt_cycle", halt_cyc, 4);
    check("ebreak_err", 32'(err), 32'(ERR_EBREAK));
    check("ebreak_retires", n_ret, 0);
    check("ebreak_lsu", n_lsu, 0);
    check("ebreak_instret", instret, 32'd0);

    // Misaligned next_pc on the second instruction
    apply_reset();
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0050_0093;
    next_pc       = 32'h8000_0004;
    sb_push(RST_PC, 32'h0050_0093, 32'd0);
    rst = 1'b0;
    halt_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 5) begin
        next_pc = 32'h8000_0006;
        sb_push(32'h8000_0004, 32'h0050_0093, 32'd1);
      end
      settle();
      if (retire) sb_retire();
      if (halt && halt_cyc == 0) halt_cyc = c;
      tick();
    end
    check("misalign_halt_cycle", halt_cyc, 9);
    check("misalign_err", 32'(err), 32'(ERR_MISALIGN));
    check("misalign_pc_kept", pc, 32'h8000_0004);
    check("misalign_instret", instret, 32'd2);
    checkb("misalign_req_valid", ifu_req_valid, 1'b0);
    rst = 1'b1;
    tick();
    check("misalign_rst_pc", pc, RST_PC);
    checkb("misalign_rst_halt", halt, 1'b0);
    check("misalign_rst_err", 32'(err), 32'(ERR_NONE));
    check("misalign_rst_instret", instret, 32'd0);

    // Fetch response never arrives: halt TIMEOUT+1 cycles after entering IF_WAIT
    apply_reset();
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b0;
    rst = 1'b0;
    settle();
    halt_cyc = 0;
    for (int c = 1; c <= 262; c++) begin
      if (c == 256) checkb("tmo_rsp_ready_before", ifu_rsp_ready, 1'b1);
      if (c == 257) begin
        checkb("tmo_rsp_ready_dropped", ifu_rsp_ready, 1'b0);
        checkb("tmo_not_yet_halted", halt, 1'b0);
      end
      if (halt && halt_cyc == 0) halt_cyc = c;
      tick();
    end
    check("tmo_halt_cycle", halt_cyc, 2 + TMO + 1);
    check("tmo_err", 32'(err), 32'(ERR_TIMEOUT));
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h1234_5678;
    tick();
    tick();
    tick();
    checkb("tmo_halt_sticky", halt, 1'b1);
    check("tmo_inst_unchanged", inst, INST_NOP);
    checkb("tmo_halt_rsp_ready", ifu_rsp_ready, 1'b0);
    checkb("tmo_halt_req_valid", ifu_req_valid, 1'b0);
    checkb("tmo_halt_retire", retire, 1'b0);

    // Handshake on the expiry cycle wins over the timeout
    apply_reset();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0030_0193;
    next_pc       = 32'h8000_0004;
    sb_push(RST_PC, 32'h0030_0193, 32'd0);
    rst = 1'b0;
    ret_cyc = 0;
    halt_cyc = 0;
    for (int c = 1; c <= 262; c++) begin
      ifu_req_ready = (c == 256);
      settle();
      if (c == 255) checkb("race_valid_c255", ifu_req_valid, 1'b1);
      if (c == 256) checkb("race_valid_c256", ifu_req_valid, 1'b1);
      if (retire && ret_cyc == 0) begin
        ret_cyc = c;
        sb_retire();
      end
      if (halt && halt_cyc == 0) halt_cyc = c;
      tick();
    end
    check("race_retire_cycle", ret_cyc, 259);
    check("race_no_halt", halt_cyc, 0);
    check("race_err", 32'(err), 32'(ERR_NONE));

    // Reset in the middle of a load abandons it; fetch restarts right after
    apply_reset();
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0000_2083;
    next_pc       = 32'h8000_0004;
    is_mem        = 1'b1;
    lsu_req_ready = 1'b1;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    rst = 1'b1;
    settle();
    checkb("midrst_lsu_valid", lsu_req_valid, 1'b0);
    checkb("midrst_retire", retire, 1'b0);
    tick();
    tick();
    is_mem = 1'b0;
    ifu_rsp_data = 32'h0050_0093;
    sb_push(RST_PC, 32'h0050_0093, 32'd0);
    rst = 1'b0;
    settle();
    checkb("midrst_c1_req_valid", ifu_req_valid, 1'b1);
    check("midrst_c1_addr", ifu_addr, RST_PC);
    ret_cyc = 0;
    for (int c = 1; c <= 5; c++) begin
      if (retire && ret_cyc == 0) begin
        ret_cyc = c;
        sb_retire();
      end
      tick();
    end
    check("midrst_retire_cycle", ret_cyc, 4);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
